// File: rtl/axi_lite_sram.sv
// axi_lite_sram
// AXI4-lite responder in front of a word-organised on-chip SRAM with
// programmable read and write latency. Out-of-range accesses get SLVERR.
//
// Parameters:
//   BASE_ADDR   byte address of word 0
//   DEPTH_WORDS number of 32-bit words (power of two, >= 2)
//   RD_LATENCY  edges from AR handshake to rvalid rise (>= 1)
//   WR_LATENCY  edges from the later AW/W handshake to bvalid rise (>= 1)
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   araddr/arvalid/arready           read address channel
//   rdata/rresp/rvalid/rready        read data channel
//   awaddr/awvalid/awready           write address channel
//   wdata/wstrb/wvalid/wready        write data channel
//   bresp/bvalid/bready              write response channel
module axi_lite_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LATENCY  = 1,
  parameter int          WR_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IW   = $clog2(DEPTH_WORDS);
  localparam int          RCW  = $clog2(RD_LATENCY + 1);
  localparam int          WCW  = $clog2(WR_LATENCY + 1);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  r_state_t         r_state_reg;
  logic [RCW-1:0]   r_cnt_reg;
  logic [31:0]      r_addr_reg;

  w_state_t         w_state_reg;
  logic [WCW-1:0]   w_cnt_reg;
  logic [31:0]      w_addr_reg;
  logic [31:0]      w_data_reg;
  logic [3:0]       w_strb_reg;

  // Offsets are computed in 33 bits: an address below BASE_ADDR borrows into
  // bit 32 and therefore compares as out of range, so no wrap is possible.
  logic [32:0]      r_off;
  logic [32:0]      w_off;
  logic             r_in_range;
  logic             w_in_range;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx;
  logic [31:0]      rd_word;
  logic             w_commit;

  assign r_off      = {1'b0, r_addr_reg} - {1'b0, BASE_ADDR};
  assign w_off      = {1'b0, w_addr_reg} - {1'b0, BASE_ADDR};
  assign r_in_range = (r_off < SPAN);
  assign w_in_range = (w_off < SPAN);
  assign r_idx      = r_off[IW+1:2];
  assign w_idx      = w_off[IW+1:2];

  // The write lands on the same edge that moves the write FSM into W_RESP.
  // Gating with rst keeps an aborted transaction from ever committing.
  assign w_commit = (w_state_reg == W_WAIT) && (w_cnt_reg == WCW'(1)) &&
                    w_in_range && !rst;

  // Byte-banked storage: each lane is its own array so strobed writes need
  // no read-modify-write. Reads sampled on a commit edge see pre-write data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] bank [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (w_commit && w_strb_reg[gi]) begin
          bank[w_idx] <= w_data_reg[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = bank[r_idx];
    end
  endgenerate

  // Read FSM. The AR edge only captures the address; R_WAIT then spans the
  // RD_LATENCY edges up to and including the edge that samples the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      r_cnt_reg   <= '0;
      r_addr_reg  <= '0;
      arready     <= 1'b1;
      rvalid      <= 1'b0;
      rdata       <= '0;
      rresp       <= 2'b00;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (arvalid) begin
            r_addr_reg  <= araddr;
            arready     <= 1'b0;
            r_cnt_reg   <= RCW'(RD_LATENCY);
            r_state_reg <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt_reg == RCW'(1)) begin
            r_cnt_reg   <= '0;
            rvalid      <= 1'b1;
            r_state_reg <= R_RESP;
            if (r_in_range) begin
              rdata <= rd_word;
              rresp <= 2'b00;
            end else begin
              rdata <= '0;
              rresp <= 2'b10;
            end
          end else begin
            r_cnt_reg <= r_cnt_reg - RCW'(1);
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid      <= 1'b0;
            arready     <= 1'b1;
            r_state_reg <= R_IDLE;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // Write FSM. A deasserted ready while idle means that channel has already
  // been captured, so no separate "seen" flags are needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      w_cnt_reg   <= '0;
      w_addr_reg  <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      awready     <= 1'b1;
      wready      <= 1'b1;
      bvalid      <= 1'b0;
      bresp       <= 2'b00;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (awready && awvalid) begin
            w_addr_reg <= awaddr;
            awready    <= 1'b0;
          end
          if (wready && wvalid) begin
            w_data_reg <= wdata;
            w_strb_reg <= wstrb;
            wready     <= 1'b0;
          end
          if (((awready && awvalid) || !awready) &&
              ((wready && wvalid) || !wready)) begin
            w_cnt_reg   <= WCW'(WR_LATENCY);
            w_state_reg <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_cnt_reg == WCW'(1)) begin
            w_cnt_reg   <= '0;
            bvalid      <= 1'b1;
            bresp       <= w_in_range ? 2'b00 : 2'b10;
            w_state_reg <= W_RESP;
          end else begin
            w_cnt_reg <= w_cnt_reg - WCW'(1);
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid      <= 1'b0;
            awready     <= 1'b1;
            wready      <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: a word model plus queues of expected
// read/write responses, pushed when stimulus is driven and popped on response.
module tb_axi_lite_sram;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 1024;
  localparam int          RD_LAT = 3;
  localparam int          WR_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [int unsigned];
  logic [33:0] rd_q [$];
  logic [1:0]  b_q [$];

  always #5 clk = ~clk;

  axi_lite_sram #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready)
  );

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int unsigned addr_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [33:0] exp_read(input logic [31:0] a);
    if (!addr_ok(a)) return {2'b10, 32'h0};
    return {2'b00, model[addr_idx(a)]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
    logic [31:0] w;
    if (addr_ok(a)) begin
      w = model.exists(addr_idx(a)) ? model[addr_idx(a)] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      model[addr_idx(a)] = w;
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    int n;
    logic [33:0] exp;
    logic [31:0] got_d;
    logic [1:0]  got_r;
    rd_q.push_back(exp_read(a));
    @(negedge clk);
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b0;
    check_value("arready_idle", 32'(arready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 100) begin
      check_value("arready_wait", 32'(arready), 32'd0);
      @(negedge clk);
      n++;
    end
    check_value("rd_latency", 32'(n), 32'(RD_LAT));
    got_d = rdata;
    got_r = rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_value("rvalid_hold", 32'(rvalid), 32'd1);
      check_value("rdata_hold", rdata, rd_q[0][31:0]);
      check_value("rresp_hold", 32'(rresp), 32'(rd_q[0][33:32]));
      check_value("arready_hold", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
    exp = rd_q.pop_front();
    $display("read  %h -> data %h resp %0d (expect %h/%0d)", a, got_d, got_r,
             exp[31:0], exp[33:32]);
    check_value("rdata", got_d, exp[31:0]);
    check_value("rresp", 32'(got_r), 32'(exp[33:32]));
    check_value("rvalid_drop", 32'(rvalid), 32'd0);
    check_value("arready_back", 32'(arready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int w_lead);
    int n;
    logic [1:0] exp;
    b_q.push_back(addr_ok(a) ? 2'b00 : 2'b10);
    model_write(a, d, s);
    @(negedge clk);
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    bready = 1'b0;
    if (w_lead == 0) begin
      awaddr  = a;
      awvalid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    if (w_lead > 0) begin
      check_value("wready_drop", 32'(wready), 32'd0);
      check_value("awready_kept", 32'(awready), 32'd1);
      for (int i = 1; i < w_lead; i++) begin
        @(negedge clk);
        check_value("wready_low", 32'(wready), 32'd0);
        check_value("awready_high", 32'(awready), 32'd1);
      end
      awaddr  = a;
      awvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    awvalid = 1'b0;
    check_value("awready_busy", 32'(awready), 32'd0);
    check_value("wready_busy", 32'(wready), 32'd0);
    n = 0;
    while (!bvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_value("wr_latency", 32'(n), 32'(WR_LAT));
    exp = b_q.pop_front();
    $display("write %h data %h strb %b -> resp %0d (expect %0d)", a, d, s,
             bresp, exp);
    check_value("bresp", 32'(bresp), 32'(exp));
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    check_value("bvalid_drop", 32'(bvalid), 32'd0);
    check_value("awready_back", 32'(awready), 32'd1);
    check_value("wready_back", 32'(wready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0;
    #1;
    check_value("rst_arready", 32'(arready), 32'd1);
    check_value("rst_awready", 32'(awready), 32'd1);
    check_value("rst_wready", 32'(wready), 32'd1);
    check_value("rst_rvalid", 32'(rvalid), 32'd0);
    check_value("rst_bvalid", 32'(bvalid), 32'd0);
    check_value("rst_rdata", rdata, 32'h0);
    check_value("rst_rresp", 32'(rresp), 32'd0);
    check_value("rst_bresp", 32'(bresp), 32'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Basic write/read, partial strobes, W ahead of AW, read backpressure.
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0);
    do_read (32'h8000_0010, 0);
    do_write(32'h8000_0020, 32'h1122_3344, 4'b1111, 0);
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0);
    do_read (32'h8000_0020, 0);
    do_write(32'h8000_0030, 32'hCAFE_F00D, 4'b1111, 3);
    do_read (32'h8000_0030, 0);
    do_read (32'h8000_0010, 5);

    // Out of range: the words an unchecked decode would alias onto are
    // seeded first and must survive the rejected writes.
    do_write(32'h8000_0000, 32'h0BAD_F00D, 4'b1111, 0);
    do_write(32'h8000_0FFC, 32'h1234_5678, 4'b1111, 0);
    do_read (32'h7FFF_FFFC, 0);
    do_read (32'h8000_1000, 0);
    do_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'b1111, 0);
    do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'b1111, 0);
    do_read (32'h8000_0000, 0);
    do_read (32'h8000_0FFC, 0);

    // Empty strobe leaves the word alone.
    do_write(32'h8000_0010, 32'h0000_0000, 4'b0000, 0);
    do_read (32'h8000_0010, 0);

    // Asynchronous reset while both FSMs are in their wait states.
    do_write(32'h8000_0014, 32'h5555_5555, 4'b1111, 0);
    @(negedge clk);
    araddr  = 32'h8000_0010; arvalid = 1'b1;
    awaddr  = 32'h8000_0014; awvalid = 1'b1;
    wdata   = 32'hAAAA_AAAA; wstrb   = 4'b1111; wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check_value("pre_rst_arready", 32'(arready), 32'd0);
    #2 rst = 1'b1;
    #1;
    $display("async reset mid-transaction applied");
    check_value("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check_value("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check_value("mid_rst_arready", 32'(arready), 32'd1);
    check_value("mid_rst_awready", 32'(awready), 32'd1);
    check_value("mid_rst_wready", 32'(wready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_read(32'h8000_0014, 0);
    do_read(32'h8000_0020, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
